ps2_kbd_rx: RTL and testbench

- Receives PS/2 keyboard frames on the ps2_clk/ps2_data pins of the game top level.
- Strips the 0xE0 (extended) and 0xF0 (break) prefixes and emits one decoded scan-code event per key action.
- Maintains held-key levels for the player controls (left, right, jump); these drive x_blue and blue_state updates in the game logic.

---
 rtl/ps2_kbd_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Brief    : PS/2 keyboard receiver. Conditions the raw bus pins, deframes
//            11-bit frames, strips E0/F0 prefixes, emits one scan-code event
//            per key action and tracks held levels for left/right/jump keys.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_ext,
  output logic       is_break,
  output logic       key_left,
  output logic       key_right,
  output logic       key_jump,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] C_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] C_BRK_PREFIX = 8'hF0;
  localparam logic [7:0] C_KEY_LEFT   = 8'h6B;
  localparam logic [7:0] C_KEY_RIGHT  = 8'h74;
  localparam logic [7:0] C_KEY_JUMP   = 8'h29;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic           clk_s1_q, clk_s2_q;
  logic           dat_s1_q, dat_s2_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           fall_q, fall_d;

  // Glitch filter: the filtered level follows the synced clock only after
  // FILTER_LEN consecutive samples that disagree with the current level.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  // Two-stage synchronisers, filter state and the registered sampling event.
  // Bus idles high, so the conditioning chain resets to the idle level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      fall_q   <= fall_d;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM, prefix handling and key levels
  // --------------------------------------------------------------------------
  state_t         state_q;
  logic [2:0]     bitcnt_q;
  logic [7:0]     shift_q;
  logic           par_q;
  logic           ext_q;
  logic           brk_q;
  logic [TCW-1:0] tout_q;
  logic [7:0]     scan_code_q;
  logic           scan_valid_q;
  logic           is_ext_q;
  logic           is_break_q;
  logic           key_left_q;
  logic           key_right_q;
  logic           key_jump_q;
  logic           parity_err_q;
  logic           frame_err_q;

  // PS/2 devices change data on the rising clock edge, so the synced data is
  // stable through the low phase and can be taken directly at the event.
  logic w_bit;
  logic w_par_ok;
  assign w_bit    = dat_s2_q;
  assign w_par_ok = ^{shift_q, par_q};

  // Deframer: one bit per sampling event, timeout abort, byte decode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      tout_q       <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      is_ext_q     <= 1'b0;
      is_break_q   <= 1'b0;
      key_left_q   <= 1'b0;
      key_right_q  <= 1'b0;
      key_jump_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (fall_q) begin
        tout_q <= '0;
        case (state_q)
          IDLE: begin
            // A high data bit at an event is a glitch, not a start bit.
            if (!w_bit) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= {w_bit, shift_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            par_q   <= w_bit;
            state_q <= STOP;
          end
          default: begin
            state_q <= IDLE;
            if (!w_bit) begin
              frame_err_q <= 1'b1;
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end else if (!w_par_ok) begin
              parity_err_q <= 1'b1;
              ext_q        <= 1'b0;
              brk_q        <= 1'b0;
            end else if (shift_q == C_EXT_PREFIX) begin
              ext_q <= 1'b1;
            end else if (shift_q == C_BRK_PREFIX) begin
              brk_q <= 1'b1;
            end else begin
              scan_code_q  <= shift_q;
              scan_valid_q <= 1'b1;
              is_ext_q     <= ext_q;
              is_break_q   <= brk_q;
              ext_q        <= 1'b0;
              brk_q        <= 1'b0;
              if (ext_q && shift_q == C_KEY_LEFT) begin
                key_left_q <= ~brk_q;
              end
              if (ext_q && shift_q == C_KEY_RIGHT) begin
                key_right_q <= ~brk_q;
              end
              if (!ext_q && shift_q == C_KEY_JUMP) begin
                key_jump_q <= ~brk_q;
              end
            end
          end
        endcase
      end else if (state_q == IDLE) begin
        tout_q <= '0;
      end else if (tout_q == TCW'(TIMEOUT_CYC - 1)) begin
        // Keyboard stopped clocking mid-frame: abandon the frame.
        tout_q      <= '0;
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        ext_q       <= 1'b0;
        brk_q       <= 1'b0;
      end else begin
        tout_q <= tout_q + 1'b1;
      end
    end
  end

  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign is_ext     = is_ext_q;
  assign is_break   = is_break_q;
  assign key_left   = key_left_q;
  assign key_right  = key_right_q;
  assign key_jump   = key_jump_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Brief    : Scoreboard bench for ps2_kbd_rx. Stimulus pushes expected events,
//            a monitor pops them whenever the DUT pulses an output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

  localparam int FL   = 8;
  localparam int TO   = 2000;
  // PS/2 half period in clk cycles (bus clock scaled up to fit the timeout).
  localparam int HALF = 100;

  localparam int K_SV   = 0;
  localparam int K_PERR = 1;
  localparam int K_FERR = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] scan_code;
  logic       scan_valid, is_ext, is_break;
  logic       key_left, key_right, key_jump;
  logic       parity_err, frame_err;

  ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .scan_valid(scan_valid), .is_ext(is_ext),
    .is_break(is_break), .key_left(key_left), .key_right(key_right),
    .key_jump(key_jump), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext, brk, l, r, j;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors = 0;
  int   events_seen = 0;
  int   last_stop_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_sv(input logic [7:0] c, input logic e, input logic b,
                        input logic l, input logic r, input logic j);
    exp_t x;
    x.kind = K_SV; x.code = c; x.ext = e; x.brk = b; x.l = l; x.r = r; x.j = j;
    q.push_back(x);
  endtask

  task automatic exp_err(input int k);
    exp_t x;
    x.kind = k; x.code = 8'h00; x.ext = 0; x.brk = 0; x.l = 0; x.r = 0; x.j = 0;
    q.push_back(x);
  endtask

  // Drive nbits bits of a frame: start, data LSB first, odd parity, stop.
  task automatic send(input logic [7:0] d, input logic bad_par,
                      input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      if (i == 10) last_stop_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (200) @(posedge clk);
  endtask

  // Monitor: every output pulse is matched against the head of the queue.
  always @(negedge clk) begin
    if (rstn && (scan_valid || parity_err || frame_err)) begin
      exp_t e;
      int   kind, lat;
      events_seen++;
      chk("pulse_exclusive", int'(scan_valid) + int'(parity_err) + int'(frame_err), 1);
      if (q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL unexpected_event: sv=%0b perr=%0b ferr=%0b code=%0h, expected none",
                 scan_valid, parity_err, frame_err, scan_code);
      end else begin
        e = q.pop_front();
        kind = scan_valid ? K_SV : (parity_err ? K_PERR : K_FERR);
        chk("event_kind", kind, e.kind);
        if (e.kind == K_SV && kind == K_SV) begin
          chk("scan_code", scan_code, e.code);
          chk("is_ext", is_ext, e.ext);
          chk("is_break", is_break, e.brk);
          chk("key_left", key_left, e.l);
          chk("key_right", key_right, e.r);
          chk("key_jump", key_jump, e.j);
          lat = cyc - last_stop_cyc;
          vectors++;
          if (lat < FL + 3 || lat > FL + 5) begin
            errors++;
            $display("FAIL latency: got %0d cycles, expected %0d..%0d", lat, FL + 3, FL + 5);
          end
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outputs"},
        {scan_code, scan_valid, is_ext, is_break, key_left, key_right,
         key_jump, parity_err, frame_err}, 0);
  endtask

  int seen;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1 chk_all_zero("reset");
    rstn = 1'b1;
    repeat (50) @(posedge clk);
    #1 chk_all_zero("post_reset");

    // Plain make code, no key affected
    exp_sv(8'h1C, 0, 0, 0, 0, 0);
    send(8'h1C, 0, 0, 11);

    // Jump make then break; F0 alone is silent
    exp_sv(8'h29, 0, 0, 0, 0, 1);
    send(8'h29, 0, 0, 11);
    exp_sv(8'h29, 0, 1, 0, 0, 0);
    send(8'hF0, 0, 0, 11);
    send(8'h29, 0, 0, 11);

    // Extended arrows: left, right held together, then left released
    exp_sv(8'h6B, 1, 0, 1, 0, 0);
    send(8'hE0, 0, 0, 11);
    send(8'h6B, 0, 0, 11);
    exp_sv(8'h74, 1, 0, 1, 1, 0);
    send(8'hE0, 0, 0, 11);
    send(8'h74, 0, 0, 11);
    exp_sv(8'h6B, 1, 1, 0, 1, 0);
    send(8'hE0, 0, 0, 11);
    send(8'hF0, 0, 0, 11);
    send(8'h6B, 0, 0, 11);

    // Bad parity; then an error between E0 and 6B clears the prefix
    exp_err(K_PERR);
    send(8'h29, 1, 0, 11);
    send(8'hE0, 0, 0, 11);
    exp_err(K_PERR);
    send(8'h74, 1, 0, 11);
    exp_sv(8'h6B, 0, 0, 0, 1, 0);
    send(8'h6B, 0, 0, 11);

    // Bad stop bit, then a timed-out partial frame, then recovery
    exp_err(K_FERR);
    send(8'h1C, 0, 1, 11);
    exp_err(K_FERR);
    send(8'h29, 0, 0, 5);
    repeat (3000) @(posedge clk);
    exp_sv(8'h1C, 0, 0, 0, 1, 0);
    send(8'h1C, 0, 0, 11);

    // Asynchronous reset mid-frame
    #1 chk("key_right_before_reset", key_right, 1);
    send(8'h29, 0, 0, 5);
    @(posedge clk); #3 rstn = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;
    repeat (100) @(posedge clk);
    #1 chk_all_zero("after_reset_release");
    exp_sv(8'h74, 1, 0, 0, 1, 0);
    send(8'hE0, 0, 0, 11);
    send(8'h74, 0, 0, 11);

    // Short clock glitches must be filtered out
    seen = events_seen;
    for (int g = 0; g < 5; g++) begin
      @(posedge clk); #1 ps2_clk = 1'b0;
      ps2_data = g[0];
      repeat (2) @(posedge clk);
      #1 ps2_clk = 1'b1;
      repeat (50) @(posedge clk);
    end
    ps2_data = 1'b1;
    repeat (TO + 200) @(posedge clk);
    #1 chk("glitch_no_events", events_seen, seen);
    chk("glitch_keys", {key_left, key_right, key_jump}, 3'b010);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
